// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: frames a run window of N cycles, then T drain cycles,
// then a one-cycle done pulse. Supports one-shot and periodic modes, pause,
// abort and a zero-length error pulse. N, T and mode are captured at start.
module counter_seq_ctrl #(
  parameter int CNT_WIDTH  = 8,
  parameter int TAIL_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  pause_i,
  input  logic                  mode_i,
  input  logic [CNT_WIDTH-1:0]  cnt_val_i,
  input  logic [TAIL_WIDTH-1:0] tail_val_i,
  output logic                  run_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  tick_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, n_q;
  logic [TAIL_WIDTH-1:0] tcnt, t_q;
  logic                  mode_q;
  logic                  err_q;
  logic                  accept, reject, run_last, tail_last;

  // Start handling: abort wins over start, so neither a run nor an error.
  assign accept    = (state == IDLE) && start_i && !abort_i && (cnt_val_i != '0);
  assign reject    = (state == IDLE) && start_i && !abort_i && (cnt_val_i == '0);
  // Compare against N-1 so the counter never has to reach N (no wrap at max N).
  assign run_last  = (state == RUN)  && !pause_i && (cnt  == n_q - CNT_WIDTH'(1));
  assign tail_last = (state == TAIL) && !pause_i && (tcnt == t_q - TAIL_WIDTH'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, pause holds via run_last/tail_last.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = RUN;
      RUN:  if (run_last)  state_nxt = (t_q != '0) ? TAIL : DONE;
      TAIL: if (tail_last) state_nxt = DONE;
      DONE: state_nxt = mode_q ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  // Run/tail counters; both return to zero when their phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tcnt <= '0;
    end else if (abort_i) begin
      cnt  <= '0;
      tcnt <= '0;
    end else begin
      case (state)
        RUN:  if (!pause_i) cnt  <= run_last  ? '0 : cnt + CNT_WIDTH'(1);
        TAIL: if (!pause_i) tcnt <= tail_last ? '0 : tcnt + TAIL_WIDTH'(1);
        default: begin
          cnt  <= '0;
          tcnt <= '0;
        end
      endcase
    end
  end

  // Run parameters are latched only on an accepted start; periodic reruns reuse them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      t_q    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      n_q    <= cnt_val_i;
      t_q    <= tail_val_i;
      mode_q <= mode_i;
    end
  end

  // Zero-length start rejection shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= reject;
  end

  assign run_o  = (state == RUN) || (state == TAIL);
  assign cnt_o  = (state == RUN) ? cnt : '0;
  assign tick_o = run_last && !abort_i;
  assign done_o = (state == DONE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl. Cycle k means the cycle after the
// k-th rising edge, counting the edge that samples start as edge 0.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, abort_i = 1'b0, pause_i = 1'b0, mode_i = 1'b0;
  logic [7:0] cnt_val_i = '0;
  logic [1:0] tail_val_i = '0;
  logic       run_o, tick_o, done_o, err_o;
  logic [7:0] cnt_o;

  int tests = 0;
  int fails = 0;

  counter_seq_ctrl #(.CNT_WIDTH(8), .TAIL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pause_i(pause_i), .mode_i(mode_i), .cnt_val_i(cnt_val_i),
    .tail_val_i(tail_val_i), .run_o(run_o), .cnt_o(cnt_o), .tick_o(tick_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Launch a run at edge 0, then scramble the capture inputs so any late
  // re-capture would be visible.
  task automatic start_run(input logic m, input logic [7:0] n, input logic [1:0] t);
    @(negedge clk);
    mode_i = m; cnt_val_i = n; tail_val_i = t; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; cnt_val_i = 8'hAA; tail_val_i = 2'd3; mode_i = ~m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++; if (run_o  !== 1'b0) begin fails++; $display("FAIL reset run_o got %b exp 0", run_o); end
    tests++; if (cnt_o  !== 8'd0) begin fails++; $display("FAIL reset cnt_o got %0d exp 0", cnt_o); end
    tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL reset tick_o got %b exp 0", tick_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset done_o got %b exp 0", done_o); end
    tests++; if (err_o  !== 1'b0) begin fails++; $display("FAIL reset err_o got %b exp 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // N=5 T=1 one-shot, ignored start mid-run, then back-to-back N=1 run at cycle 8.
  task automatic test_oneshot_tail;
    logic e_run, e_tick, e_done;
    logic [7:0] e_cnt;
    start_run(1'b0, 8'd5, 2'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i = (k == 3) || (k == 8);
      if (k == 8) begin cnt_val_i = 8'd1; tail_val_i = 2'd0; mode_i = 1'b0; end
      #1;
      e_run  = (k >= 1 && k <= 6) || (k == 9);
      e_cnt  = (k <= 5) ? 8'(k - 1) : 8'd0;
      e_tick = (k == 5) || (k == 9);
      e_done = (k == 7) || (k == 10);
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL oneshot run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL oneshot cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL oneshot tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL oneshot done k=%0d got %b exp %b", k, done_o, e_done); end
    end
    start_i = 1'b0;
  endtask

  // N=3 T=0: straight from RUN to DONE.
  task automatic test_no_tail;
    logic e_run, e_tick, e_done;
    logic [7:0] e_cnt;
    start_run(1'b0, 8'd3, 2'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      e_run  = (k <= 3);
      e_cnt  = (k <= 3) ? 8'(k - 1) : 8'd0;
      e_tick = (k == 3);
      e_done = (k == 4);
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL notail run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL notail cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL notail tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL notail done k=%0d got %b exp %b", k, done_o, e_done); end
    end
  endtask

  // Periodic N=2 T=2: done every 5 cycles; abort at cycle 12 (last RUN cycle).
  task automatic test_periodic_abort;
    logic e_run, e_tick, e_done;
    logic [7:0] e_cnt;
    int p;
    start_run(1'b1, 8'd2, 2'd2);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      abort_i = (k == 12);
      #1;
      p = (k - 1) % 5;
      if (k <= 12) begin
        e_run  = (p <= 3);
        e_cnt  = (p <= 1) ? 8'(p) : 8'd0;
        e_tick = (p == 1) && (k != 12);
        e_done = (p == 4);
      end else begin
        e_run = 1'b0; e_cnt = 8'd0; e_tick = 1'b0; e_done = 1'b0;
      end
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL periodic run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL periodic cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL periodic tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL periodic done k=%0d got %b exp %b", k, done_o, e_done); end
    end
    abort_i = 1'b0;
  endtask

  // Pause in RUN holds the count; pause on the last RUN cycle defers tick;
  // pause in TAIL stretches it; pause in DONE is ignored.
  task automatic test_pause;
    logic e_run, e_tick, e_done;
    logic [7:0] e_cnt;
    start_run(1'b0, 8'd4, 2'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pause_i = (k == 2) || (k == 3);
      #1;
      e_run  = (k <= 6);
      e_cnt  = (k == 1) ? 8'd0 : (k <= 4) ? 8'd1 : (k == 5) ? 8'd2 : (k == 6) ? 8'd3 : 8'd0;
      e_tick = (k == 6);
      e_done = (k == 7);
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL pause run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL pause cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL pause tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL pause done k=%0d got %b exp %b", k, done_o, e_done); end
    end
    pause_i = 1'b0;
    start_run(1'b0, 8'd2, 2'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      pause_i = (k == 2) || (k == 4) || (k == 6);
      #1;
      e_run  = (k <= 5);
      e_cnt  = (k == 2 || k == 3) ? 8'd1 : 8'd0;
      e_tick = (k == 3);
      e_done = (k == 6);
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL pause2 run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL pause2 cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL pause2 tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL pause2 done k=%0d got %b exp %b", k, done_o, e_done); end
    end
    pause_i = 1'b0;
  endtask

  // Zero-length start gives one err pulse; start with abort gives nothing.
  task automatic test_err_abort_start;
    @(negedge clk);
    start_i = 1'b1; cnt_val_i = 8'd0; tail_val_i = 2'd1; mode_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err pulse got %b exp 1", err_o); end
    tests++; if (run_o !== 1'b0) begin fails++; $display("FAIL err run got %b exp 0", run_o); end
    @(negedge clk);
    #1;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err clear got %b exp 0", err_o); end
    start_i = 1'b1; abort_i = 1'b1; cnt_val_i = 8'd5;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      tests++; if (run_o !== 1'b0) begin fails++; $display("FAIL abortstart run k=%0d got %b exp 0", k, run_o); end
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL abortstart err k=%0d got %b exp 0", k, err_o); end
      @(negedge clk);
    end
  endtask

  // Max N with T=3: count climbs to 254 without wrapping; done at cycle 259.
  task automatic test_long_and_reset;
    logic e_run, e_tick, e_done;
    logic [7:0] e_cnt;
    start_run(1'b0, 8'd255, 2'd3);
    for (int k = 1; k <= 261; k++) begin
      @(negedge clk);
      #1;
      e_run  = (k <= 258);
      e_cnt  = (k <= 255) ? 8'(k - 1) : 8'd0;
      e_tick = (k == 255);
      e_done = (k == 259);
      tests++; if (run_o  !== e_run)  begin fails++; $display("FAIL long run k=%0d got %b exp %b", k, run_o, e_run); end
      tests++; if (cnt_o  !== e_cnt)  begin fails++; $display("FAIL long cnt k=%0d got %0d exp %0d", k, cnt_o, e_cnt); end
      tests++; if (tick_o !== e_tick) begin fails++; $display("FAIL long tick k=%0d got %b exp %b", k, tick_o, e_tick); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL long done k=%0d got %b exp %b", k, done_o, e_done); end
    end
    start_run(1'b1, 8'd10, 2'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++; if (cnt_o !== 8'd2) begin fails++; $display("FAIL midrun cnt got %0d exp 2", cnt_o); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (run_o  !== 1'b0) begin fails++; $display("FAIL asyncrst run got %b exp 0", run_o); end
    tests++; if (cnt_o  !== 8'd0) begin fails++; $display("FAIL asyncrst cnt got %0d exp 0", cnt_o); end
    tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL asyncrst tick got %b exp 0", tick_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL asyncrst done got %b exp 0", done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (run_o !== 1'b0) begin fails++; $display("FAIL postrst run got %b exp 0", run_o); end
  endtask

  initial begin
    test_reset();
    test_oneshot_tail();
    test_no_tail();
    test_periodic_abort();
    test_pause();
    test_err_abort_start();
    test_long_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
